// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtract sequencer.
package serial_sub_pkg;

    // Sequencer states, 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the bit counter for a given operand width.
    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage : serial_sub_pkg

// File: rtl/serial_sub_ctrl_full_sub.sv
// One-bit full subtractor: d = x - y - bin, br = borrow out.
// Purely combinational; the sequencer feeds it one bit per clock.
module full_sub (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic br,
    output logic d
);

    // Difference bit is the parity of the three inputs.
    assign d  = x ^ y ^ bin;

    // A borrow is needed whenever y + bin exceeds x.
    assign br = (~x & y) | (~x & bin) | (y & bin);

endmodule : full_sub

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtract sequencer. Accepts a start with operands a, b and an
// initial borrow, then pushes one bit per clock (LSB first) through a single
// full_sub cell, carrying the borrow in a register between cycles. The result
// appears on diff/bout together with a one-cycle done pulse.
module serial_sub_ctrl
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int            CW       = cnt_w(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;
    logic             borrow;
    logic [CW-1:0]    cnt;

    logic             cell_d;
    logic             cell_br;
    logic [WIDTH-1:0] r_next;
    logic             accept;
    logic             last_bit;

    // The single arithmetic cell always looks at the current LSBs.
    full_sub u_cell (a_sh[0], b_sh[0], borrow, cell_br, cell_d);

    // Result register value after this cycle's bit is shifted in at the top.
    assign r_next   = {cell_d, r_sh[WIDTH-1:1]};
    assign accept   = (state == IDLE) && start;
    assign last_bit = (state == RUN) && (cnt == CNT_LAST);

    // Next-state logic for the IDLE -> RUN -> DONE -> IDLE sequence.
    always_comb begin
        // NOTE: default first so every path assigns state_next; otherwise a latch is inferred.
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (cnt == CNT_LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register; reset returns to IDLE and aborts any operation.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operand/result shift registers, borrow register and bit counter.
    always_ff @(posedge clk) begin
        // NOTE: these are plain flops, not a memory, so they are cleared on reset
        // and never show stale operands after an abort.
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            r_sh   <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
        end else if (accept) begin
            a_sh   <= a;
            b_sh   <= b;
            borrow <= bin;
            cnt    <= '0;
        end else if (state == RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            r_sh   <= r_next;
            borrow <= cell_br;
            if (cnt != CNT_LAST) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // Registered status flags derived from the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            ready <= (state_next == IDLE);
            busy  <= (state_next != IDLE);
            done  <= (state_next == DONE);
        end
    end

    // Result registers update only on completion, so partial values never leak.
    always_ff @(posedge clk) begin
        if (rst) begin
            diff <= '0;
            bout <= 1'b0;
        end else if (last_bit) begin
            diff <= r_next;
            bout <= cell_br;
        end
    end

endmodule : serial_sub_ctrl

// File: tb/tb_serial_sub_ctrl.sv
// Directed bench for serial_sub_ctrl: a WIDTH=8 instance for the directed
// vectors and a WIDTH=4 instance for the exhaustive back-to-back sweep.
module tb_serial_sub_ctrl;

    logic       clk = 1'b0;
    int         tests_run = 0;
    int         tests_failed = 0;
    int         cyc = 0;

    // WIDTH=8 instance signals
    logic       rst8 = 1'b1;
    logic       start8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       bin8 = 1'b0;
    logic       ready8, busy8, done8, bout8;
    logic [7:0] diff8;

    // WIDTH=4 instance signals
    logic       rst4 = 1'b1;
    logic       start4 = 1'b0;
    logic [3:0] a4 = '0;
    logic [3:0] b4 = '0;
    logic       bin4 = 1'b0;
    logic       ready4, busy4, done4, bout4;
    logic [3:0] diff4;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_sub_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .ready(ready8), .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
    );

    serial_sub_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst4), .start(start4), .a(a4), .b(b4), .bin(bin4),
        .ready(ready4), .busy(busy4), .done(done4), .diff(diff4), .bout(bout4)
    );

    // Runs one WIDTH=8 operation. Optionally pulses start with a=AA at the
    // given cycle after acceptance (0 disables). Returns the result captured
    // on the first done, done latency, busy cycle count and done pulse count.
    task automatic op8(input logic [7:0] ia, input logic [7:0] ib, input logic ibin,
                       input int inject_at,
                       output logic [7:0] od, output logic ob,
                       output int lat, output int busy_n, output int dones);
        int g;
        g = 0;
        while (!ready8 && g < 50) begin
            @(negedge clk);
            g++;
        end
        tests_run++;
        if (ready8 !== 1'b1) begin
            tests_failed++;
            $display("FAIL op8_ready: ready=%b required 1", ready8);
        end
        a8 = ia; b8 = ib; bin8 = ibin; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        a8 = ~ia; b8 = ~ib; bin8 = ~ibin;
        od = 'x; ob = 1'bx; lat = -1; busy_n = 0; dones = 0;
        for (int c = 1; c <= 20; c++) begin
            if (busy8) busy_n++;
            if (c == inject_at) begin
                start8 = 1'b1;
                a8 = 8'hAA;
            end
            if (c == inject_at + 1) start8 = 1'b0;
            @(posedge clk);
            @(negedge clk);
            if (done8) begin
                dones++;
                if (lat < 0) begin
                    lat = c;
                    od = diff8;
                    ob = bout8;
                end
            end
        end
        start8 = 1'b0;
    endtask

    task automatic test_reset();
        rst8 = 1'b1; rst4 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if ({ready8, busy8, done8, bout8, diff8} !== {4'b1000, 8'h00}) begin
            tests_failed++;
            $display("FAIL reset_w8: rdy/busy/done/bout/diff=%b%b%b%b/%h required 1000/00",
                     ready8, busy8, done8, bout8, diff8);
        end
        tests_run++;
        if ({ready4, busy4, done4, bout4, diff4} !== {4'b1000, 4'h0}) begin
            tests_failed++;
            $display("FAIL reset_w4: rdy/busy/done/bout/diff=%b%b%b%b/%h required 1000/0",
                     ready4, busy4, done4, bout4, diff4);
        end
        rst8 = 1'b0; rst4 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [7:0] d; logic bo; int lat, bn, dn;
        op8(8'h05, 8'h03, 1'b0, 0, d, bo, lat, bn, dn);
        tests_run++;
        if (d !== 8'h02 || bo !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_05_03: diff=%h bout=%b required 02/0", d, bo);
        end
        tests_run++;
        if (lat !== 8) begin
            tests_failed++;
            $display("FAIL basic_latency: got %0d required 8", lat);
        end
        tests_run++;
        if (bn !== 9) begin
            tests_failed++;
            $display("FAIL basic_busy_cycles: got %0d required 9", bn);
        end
        tests_run++;
        if (dn !== 1) begin
            tests_failed++;
            $display("FAIL basic_done_pulses: got %0d required 1", dn);
        end
    endtask

    task automatic test_vectors();
        logic [7:0] va [4] = '{8'h03, 8'h00, 8'hFF, 8'h80};
        logic [7:0] vb [4] = '{8'h05, 8'h00, 8'hFF, 8'h01};
        logic       vc [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [7:0] ed [4] = '{8'hFE, 8'hFF, 8'hFF, 8'h7F};
        logic       eb [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [7:0] d; logic bo; int lat, bn, dn;
        for (int i = 0; i < 4; i++) begin
            op8(va[i], vb[i], vc[i], 0, d, bo, lat, bn, dn);
            tests_run++;
            if (d !== ed[i] || bo !== eb[i] || dn !== 1) begin
                tests_failed++;
                $display("FAIL vector_%0d: diff=%h bout=%b dones=%0d required %h/%b/1",
                         i, d, bo, dn, ed[i], eb[i]);
            end
        end
    endtask

    task automatic test_ignore_start();
        logic [7:0] d; logic bo; int lat, bn, dn;
        op8(8'h05, 8'h03, 1'b0, 3, d, bo, lat, bn, dn);
        tests_run++;
        if (d !== 8'h02 || bo !== 1'b0) begin
            tests_failed++;
            $display("FAIL ignore_start_result: diff=%h bout=%b required 02/0", d, bo);
        end
        tests_run++;
        if (dn !== 1 || lat !== 8) begin
            tests_failed++;
            $display("FAIL ignore_start_done: dones=%0d lat=%0d required 1/8", dn, lat);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [7:0] d; logic bo; int lat, bn, dn, seen;
        // Leave a non-zero result on the outputs first.
        op8(8'h03, 8'h05, 1'b0, 0, d, bo, lat, bn, dn);
        a8 = 8'h10; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tests_run++;
        if ({busy8, ready8, done8, bout8, diff8} !== {4'b0100, 8'h00}) begin
            tests_failed++;
            $display("FAIL reset_mid_run: busy/rdy/done/bout/diff=%b%b%b%b/%h required 0100/00",
                     busy8, ready8, done8, bout8, diff8);
        end
        rst8 = 1'b0;
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (done8 || busy8) seen++;
        end
        tests_run++;
        if (seen !== 0) begin
            tests_failed++;
            $display("FAIL reset_no_done: activity cycles=%0d required 0", seen);
        end
        op8(8'h80, 8'h01, 1'b0, 0, d, bo, lat, bn, dn);
        tests_run++;
        if (d !== 8'h7F || bo !== 1'b0 || lat !== 8) begin
            tests_failed++;
            $display("FAIL reset_restart: diff=%h bout=%b lat=%0d required 7F/0/8", d, bo, lat);
        end
    endtask

    task automatic test_back_to_back_w4();
        int prev_acc;
        prev_acc = -1;
        for (int i = 0; i < 512; i++) begin
            logic [3:0] ta, tb_v;
            logic       tc;
            logic [4:0] ex;
            int         g;
            bit         got;
            ta   = i[8:5];
            tb_v = i[4:1];
            tc   = i[0];
            ex   = {1'b0, ta} - {1'b0, tb_v} - {4'b0000, tc};
            g = 0;
            while (!ready4 && g < 20) begin
                @(negedge clk);
                g++;
            end
            if (ready4 !== 1'b1) begin
                tests_run++;
                tests_failed++;
                $display("FAIL w4_ready_%0d: ready=%b required 1", i, ready4);
            end
            a4 = ta; b4 = tb_v; bin4 = tc; start4 = 1'b1;
            @(posedge clk);
            @(negedge clk);
            start4 = 1'b0;
            if (prev_acc >= 0) begin
                tests_run++;
                if (cyc - prev_acc !== 6) begin
                    tests_failed++;
                    $display("FAIL w4_period_%0d: got %0d required 6", i, cyc - prev_acc);
                end
            end
            prev_acc = cyc;
            got = 1'b0;
            g = 0;
            while (!got && g < 20) begin
                @(posedge clk);
                @(negedge clk);
                g++;
                if (done4) got = 1'b1;
            end
            tests_run++;
            if (!got || diff4 !== ex[3:0] || bout4 !== ex[4]) begin
                tests_failed++;
                $display("FAIL w4_op_%0d a=%h b=%h bin=%b: done=%b diff=%h bout=%b required %h/%b",
                         i, ta, tb_v, tc, got, diff4, bout4, ex[3:0], ex[4]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_vectors();
        test_ignore_start();
        test_reset_mid_run();
        test_back_to_back_w4();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_serial_sub_ctrl
